// File: rtl/uart_lsu_bridge.sv
// LSU peripheral-port register front-end for the UART: TX push, RX pop with frame
// decode, baud programming, sticky error status and a level interrupt.
module uart_lsu_bridge #(
  parameter logic [15:0] BRD_RST = 16'd325,
  parameter int unsigned RX_LAT  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_wr,
  output logic        o_rx_get,
  output logic [15:0] o_brd,
  input  logic        i_tx_empty,
  input  logic        i_tx_full,
  input  logic        i_rx_avail,
  input  logic        i_rx_full,
  input  logic [9:0]  i_rx_frame,
  output logic        o_irq
);

  typedef enum logic [1:0] {StIdle, StTxPush, StRxWait, StResp} state_e;

  localparam logic [2:0] RxLastCnt = 3'(RX_LAT);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [7:0]  r_tx_data;
  logic [15:0] r_brd;
  logic [1:0]  r_ctrl;
  logic        r_tx_ovf, r_rx_unf, r_fe;
  logic        r_irq;

  logic        w_accept, w_write, w_aligned;
  logic        w_sel_tx, w_sel_rx, w_sel_st, w_sel_baud, w_sel_ctrl;
  logic        w_wr_acc, w_rd_acc;
  logic        w_tx_ovf_set, w_rx_unf_set, w_fe_set, w_rx_done, w_frame_err;
  logic [2:0]  w_w1c;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // Simultaneous read+write requests resolve to a write.
  assign w_accept   = (r_state == StIdle) & i_cs & (i_wr_en | i_rd_en);
  assign w_write    = i_wr_en;
  assign w_wr_acc   = w_accept & w_write;
  assign w_rd_acc   = w_accept & ~w_write;
  assign w_aligned  = (i_addr[1:0] == 2'b00);
  assign w_sel_tx   = w_aligned & (i_addr[4:2] == 3'd0);
  assign w_sel_rx   = w_aligned & (i_addr[4:2] == 3'd1);
  assign w_sel_st   = w_aligned & (i_addr[4:2] == 3'd2);
  assign w_sel_baud = w_aligned & (i_addr[4:2] == 3'd3);
  assign w_sel_ctrl = w_aligned & (i_addr[4:2] == 3'd4);

  assign w_rx_done    = (r_state == StRxWait) & (r_cnt == RxLastCnt);
  assign w_frame_err  = i_rx_frame[0] | ~i_rx_frame[9];
  assign w_tx_ovf_set = w_wr_acc & w_sel_tx & i_tx_full;
  assign w_rx_unf_set = w_rd_acc & w_sel_rx & ~i_rx_avail;
  assign w_fe_set     = w_rx_done & w_frame_err;
  assign w_w1c        = (w_wr_acc & w_sel_st) ? i_wdata[6:4] : 3'b000;

  assign w_unused = ^i_wdata[31:16];

  // RXDATA is not muxed here; its value arrives from the frame capture path.
  always_comb begin
    w_rd_val = '0;
    if (w_sel_st) begin
      w_rd_val[6:0] = {r_fe, r_rx_unf, r_tx_ovf, i_rx_full, i_rx_avail, i_tx_full, i_tx_empty};
    end else if (w_sel_baud) begin
      w_rd_val[15:0] = r_brd;
    end else if (w_sel_ctrl) begin
      w_rd_val[1:0] = r_ctrl;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_write & w_sel_tx & ~i_tx_full) begin
            w_state_nxt = StTxPush;
          end else if (~w_write & w_sel_rx & i_rx_avail) begin
            w_state_nxt = StRxWait;
          end else begin
            w_state_nxt = StResp;
          end
        end
      end
      StTxPush: w_state_nxt = StIdle;
      StRxWait: if (r_cnt == RxLastCnt) w_state_nxt = StResp;
      StResp:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_ack    = (r_state == StTxPush) | (r_state == StResp);
    o_tx_wr  = (r_state == StTxPush);
    o_rx_get = (r_state == StRxWait) & (r_cnt == 3'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_tx_data <= '0;
      r_brd     <= BRD_RST;
      r_ctrl    <= '0;
      r_tx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
      r_fe      <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_cnt <= (r_state == StRxWait) ? r_cnt + 3'd1 : 3'd0;

      if (w_rd_acc & ~(w_sel_rx & i_rx_avail)) begin
        r_rdata <= w_rd_val;
      end else if (w_rx_done) begin
        r_rdata <= {23'd0, w_frame_err, i_rx_frame[8:1]};
      end

      if (w_wr_acc & w_sel_tx & ~i_tx_full) r_tx_data <= i_wdata[7:0];
      if (w_wr_acc & w_sel_baud) r_brd <= i_wdata[15:0];
      if (w_wr_acc & w_sel_ctrl) r_ctrl <= i_wdata[1:0];

      // Set wins over a same-cycle clear.
      r_tx_ovf <= (r_tx_ovf & ~w_w1c[0]) | w_tx_ovf_set;
      r_rx_unf <= (r_rx_unf & ~w_w1c[1]) | w_rx_unf_set;
      r_fe     <= (r_fe & ~w_w1c[2]) | w_fe_set;

      r_irq <= (r_ctrl[0] & i_rx_avail) | (r_ctrl[1] & i_tx_empty) |
               r_tx_ovf | r_rx_unf | r_fe;
    end
  end

  assign o_rdata   = r_rdata;
  assign o_tx_data = r_tx_data;
  assign o_brd     = r_brd;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_uart_lsu_bridge.sv
// Directed self-checking bench for uart_lsu_bridge with a small UART receive-latency model.
module tb_uart_lsu_bridge;

  localparam int RX_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, wr_en, rd_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack, tx_wr, rx_get, irq;
  logic [7:0]  tx_data;
  logic [15:0] brd;
  logic        tx_empty, tx_full, rx_avail, rx_full;
  logic [9:0]  rx_frame = 10'h000;
  logic [9:0]  frame_val;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tx_wr  = 0;
  int n_rx_get = 0;
  int model_cnt = 0;
  logic model_armed = 1'b0;

  always #5 clk = ~clk;

  uart_lsu_bridge #(.BRD_RST(16'd325), .RX_LAT(RX_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack),
    .o_tx_data(tx_data), .o_tx_wr(tx_wr), .o_rx_get(rx_get), .o_brd(brd),
    .i_tx_empty(tx_empty), .i_tx_full(tx_full), .i_rx_avail(rx_avail),
    .i_rx_full(rx_full), .i_rx_frame(rx_frame), .o_irq(irq)
  );

  // Frame is garbage until RX_LAT cycles after the pop strobe.
  always @(posedge clk) begin
    if (tx_wr) n_tx_wr <= n_tx_wr + 1;
    if (rx_get) begin
      n_rx_get    <= n_rx_get + 1;
      rx_frame    <= 10'h000;
      model_cnt   <= 1;
      model_armed <= 1'b1;
    end else if (model_armed) begin
      if (model_cnt == RX_LAT - 1) begin
        rx_frame    <= frame_val;
        model_armed <= 1'b0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end

  task automatic lsu_xfer(input logic wr, input logic rd, input logic [4:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rdat,
                          output logic txw);
    @(negedge clk);
    cs = 1'b1; wr_en = wr; rd_en = rd; addr = a; wdata = d;
    lat = -1; rdat = '0; txw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i; rdat = rdata; txw = tx_wr;
        break;
      end
    end
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    int lat; logic [31:0] rd; logic txw;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ack, tx_wr, rx_get, irq} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {ack, tx_wr, rx_get, irq});
    end
    n_checks++;
    if (rdata !== 32'h0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got rdata=%h tx_data=%h expected 0", rdata, tx_data);
    end
    n_checks++;
    if (brd !== 16'd325) begin
      n_fail++; $display("FAIL reset_brd: got %0d expected 325", brd);
    end
    lsu_xfer(1'b0, 1'b1, 5'h0C, 32'h0, lat, rd, txw);
    n_checks++;
    if (lat !== 1 || rd !== 32'h0000_0145) begin
      n_fail++; $display("FAIL read_baud: got lat=%0d rdata=%h expected lat=1 rdata=00000145", lat, rd);
    end
    lsu_xfer(1'b0, 1'b1, 5'h10, 32'h0, lat, rd, txw);
    n_checks++;
    if (lat !== 1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL read_ctrl: got lat=%0d rdata=%h expected lat=1 rdata=0", lat, rd);
    end
  endtask

  task automatic test_tx;
    int lat, base; logic [31:0] rd; logic txw;
    tx_full = 1'b0;
    base = n_tx_wr;
    lsu_xfer(1'b1, 1'b0, 5'h00, 32'hFFFF_FF5A, lat, rd, txw);
    repeat (2) @(negedge clk);
    n_checks++;
    if (lat !== 1 || txw !== 1'b1 || tx_data !== 8'h5A) begin
      n_fail++; $display("FAIL tx_push: got lat=%0d tx_wr@ack=%b tx_data=%h expected 1 1 5a", lat, txw, tx_data);
    end
    n_checks++;
    if (n_tx_wr - base !== 1) begin
      n_fail++; $display("FAIL tx_wr_pulses: got %0d expected 1", n_tx_wr - base);
    end
    tx_full = 1'b1;
    base = n_tx_wr;
    lsu_xfer(1'b1, 1'b0, 5'h00, 32'h0000_00A5, lat, rd, txw);
    repeat (2) @(negedge clk);
    n_checks++;
    if (lat !== 1 || n_tx_wr - base !== 0 || tx_data !== 8'h5A) begin
      n_fail++; $display("FAIL tx_drop: got lat=%0d pulses=%0d tx_data=%h expected 1 0 5a", lat, n_tx_wr - base, tx_data);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_tx_ovf: got %b expected 1", irq);
    end
    lsu_xfer(1'b0, 1'b1, 5'h08, 32'h0, lat, rd, txw);
    n_checks++;
    if (rd !== 32'h12) begin
      n_fail++; $display("FAIL status_ovf: got %h expected 00000012", rd);
    end
    lsu_xfer(1'b1, 1'b0, 5'h08, 32'h10, lat, rd, txw);
    lsu_xfer(1'b0, 1'b1, 5'h08, 32'h0, lat, rd, txw);
    n_checks++;
    if (rd !== 32'h02) begin
      n_fail++; $display("FAIL status_w1c: got %h expected 00000002", rd);
    end
    tx_full = 1'b0;
  endtask

  task automatic test_rx_good;
    int lat, base; logic [31:0] rd; logic txw;
    rx_avail  = 1'b1;
    frame_val = 10'b1_1010_0101_0;
    base = n_rx_get;
    lsu_xfer(1'b0, 1'b1, 5'h04, 32'h0, lat, rd, txw);
    n_checks++;
    if (lat !== RX_LAT + 2 || rd !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL rx_good: got lat=%0d rdata=%h expected lat=%0d rdata=000000a5", lat, rd, RX_LAT + 2);
    end
    n_checks++;
    if (n_rx_get - base !== 1) begin
      n_fail++; $display("FAIL rx_get_pulses: got %0d expected 1", n_rx_get - base);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_rx_good: got %b expected 0", irq);
    end
  endtask

  task automatic test_rx_errors;
    int lat, base; logic [31:0] rd; logic txw;
    rx_avail  = 1'b1;
    frame_val = 10'b0_1010_0101_0;
    lsu_xfer(1'b0, 1'b1, 5'h04, 32'h0, lat, rd, txw);
    repeat (2) @(negedge clk);
    n_checks++;
    if (lat !== RX_LAT + 2 || rd !== 32'h0000_01A5) begin
      n_fail++; $display("FAIL rx_bad_stop: got lat=%0d rdata=%h expected lat=%0d rdata=000001a5", lat, rd, RX_LAT + 2);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_fe: got %b expected 1", irq);
    end
    lsu_xfer(1'b0, 1'b1, 5'h08, 32'h0, lat, rd, txw);
    n_checks++;
    if (rd !== 32'h44) begin
      n_fail++; $display("FAIL status_fe: got %h expected 00000044", rd);
    end
    rx_avail = 1'b0;
    base = n_rx_get;
    lsu_xfer(1'b0, 1'b1, 5'h04, 32'h0, lat, rd, txw);
    n_checks++;
    if (lat !== 1 || rd !== 32'h0 || n_rx_get - base !== 0) begin
      n_fail++; $display("FAIL rx_unf: got lat=%0d rdata=%h pulses=%0d expected 1 0 0", lat, rd, n_rx_get - base);
    end
    lsu_xfer(1'b0, 1'b1, 5'h08, 32'h0, lat, rd, txw);
    n_checks++;
    if (rd !== 32'h60) begin
      n_fail++; $display("FAIL status_unf: got %h expected 00000060", rd);
    end
    lsu_xfer(1'b1, 1'b0, 5'h08, 32'h70, lat, rd, txw);
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_irq_baud;
    int lat; logic [31:0] rd; logic txw;
    tx_empty = 1'b1;
    lsu_xfer(1'b1, 1'b0, 5'h10, 32'h2, lat, rd, txw);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_early: got %b expected 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_ie_tx: got %b expected 1", irq);
    end
    lsu_xfer(1'b1, 1'b0, 5'h0C, 32'h1234_0010, lat, rd, txw);
    n_checks++;
    if (lat !== 1 || brd !== 16'h0010) begin
      n_fail++; $display("FAIL baud_write: got lat=%0d brd=%h expected 1 0010", lat, brd);
    end
    lsu_xfer(1'b1, 1'b0, 5'h0E, 32'hFFFF_FFFF, lat, rd, txw);
    lsu_xfer(1'b0, 1'b1, 5'h0C, 32'h0, lat, rd, txw);
    n_checks++;
    if (rd !== 32'h10) begin
      n_fail++; $display("FAIL baud_read: got %h expected 00000010", rd);
    end
    lsu_xfer(1'b0, 1'b1, 5'h14, 32'h0, lat, rd, txw);
    n_checks++;
    if (lat !== 1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got lat=%0d rdata=%h expected 1 0", lat, rd);
    end
    lsu_xfer(1'b1, 1'b1, 5'h10, 32'h1, lat, rd, txw);
    lsu_xfer(1'b0, 1'b1, 5'h10, 32'h0, lat, rd, txw);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL wr_rd_as_write: got %h expected 00000001", rd);
    end
    lsu_xfer(1'b1, 1'b0, 5'h10, 32'h0, lat, rd, txw);
    tx_empty = 1'b0;
  endtask

  task automatic test_rst_mid;
    int lat, acks, base; logic [31:0] rd; logic txw;
    rx_avail  = 1'b1;
    frame_val = 10'b1_0011_1100_0;
    @(negedge clk);
    cs = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 5'h04;
    @(negedge clk);
    n_checks++;
    if (rx_get !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_rx_get: got %b expected 1", rx_get);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cs = 1'b0; rd_en = 1'b0;
    n_checks++;
    if ({ack, tx_wr, rx_get, irq} !== 4'b0000 || brd !== 16'd325 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_outputs: got ctl=%b brd=%0d tx_data=%h expected 0000 325 00",
                         {ack, tx_wr, rx_get, irq}, brd, tx_data);
    end
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks);
    end
    rx_avail = 1'b0;
    base = n_tx_wr;
    lsu_xfer(1'b1, 1'b0, 5'h00, 32'h3C, lat, rd, txw);
    @(negedge clk);
    n_checks++;
    if (lat !== 1 || txw !== 1'b1 || tx_data !== 8'h3C || n_tx_wr - base !== 1) begin
      n_fail++; $display("FAIL post_rst_tx: got lat=%0d tx_wr@ack=%b tx_data=%h pulses=%0d expected 1 1 3c 1",
                         lat, txw, tx_data, n_tx_wr - base);
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    tx_empty = 1'b0; tx_full = 1'b0; rx_avail = 1'b0; rx_full = 1'b0;
    frame_val = 10'h000;
    test_reset();
    test_tx();
    test_rx_good();
    test_rx_errors();
    test_irq_baud();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_lsu_bridge.md
Name: uart_lsu_bridge

Overview:
Memory-mapped register front-end that connects the pipelined LSU's peripheral port to the UART top. It converts LSU load/store requests into UART control:
- transmit byte pushes,
- receive FIFO pops with frame decode,
- baud divisor programming.

It also tracks sticky error status and raises a level interrupt. It sits directly upstream of the UART and drives its data, strobe and baud inputs.

Parameters:
BRD_RST, 16'd325, baud divisor loaded on reset
RX_LAT, 2, cycles from rx_get pulse to valid rx_frame (legal range 1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cs  in  1  LSU request select; held until ack
wr_en  in  1  store request
rd_en  in  1  load request
addr  in  5  byte address; bits [1:0] must be 0
wdata  in  32  store data
rdata  out  32  load data, valid while ack=1
ack  out  1  one-cycle request completion
tx_data  out  8  byte to UART transmitter (uart_in)
tx_wr  out  1  one-cycle push strobe (UART busy input)
rx_get  out  1  one-cycle pop strobe (UART Get input)
brd  out  16  baud divisor to UART
tx_empty  in  1  UART Fe
tx_full  in  1  UART Ff
rx_avail  in  1  UART rd_flag, receive data present
rx_full  in  1  UART Rxff
rx_frame  in  10  UART uart_out: bit0 start, bits[8:1] data LSB-first, bit9 stop
irq  out  1  level interrupt

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset values:
  - rdata=0, ack=0, tx_data=0, tx_wr=0, rx_get=0, irq=0.
  - brd=BRD_RST, ctrl=0, sticky bits=0, FSM=IDLE.
- Register map:
  - 0x00 TXDATA: W; byte = wdata[7:0].
  - 0x04 RXDATA: R; bits [7:0] data, bit8 frame error of this byte.
  - 0x08 STATUS: R; bits 0..6 listed below; W1C on bits 4..6 only.
    - bit0 tx_empty, bit1 tx_full, bit2 rx_avail, bit3 rx_full.
    - bit4 tx_ovf, bit5 rx_unf, bit6 fe_sticky.
  - 0x0C BAUD: R/W; [15:0] only.
  - 0x10 CTRL: R/W; bit0 ie_rx, bit1 ie_tx.
  - All unused bits read 0.
- FSM states: IDLE, TX_PUSH, RX_WAIT, RESP.
  - IDLE samples cs only in IDLE. cs with both wr_en and rd_en is treated as a write. cs with neither is ignored.
  - Write to BAUD, CTRL or STATUS: register updates on the accept edge; go to RESP. ack is high the cycle after accept (latency 1).
  - Write to TXDATA with tx_full=0: latch tx_data; go to TX_PUSH. TX_PUSH drives tx_wr=1 and ack=1 for exactly one cycle, then returns to IDLE.
  - Write to TXDATA with tx_full=1: byte dropped, tx_ovf set, no tx_wr; go to RESP.
  - Read of RXDATA with rx_avail=1: rx_get=1 the cycle after accept; enter RX_WAIT. A counter runs RX_LAT cycles. On the final cycle, capture rx_frame[8:1]. Frame error = (rx_frame[0]!=0) | (rx_frame[9]!=1); if set, also set fe_sticky. Go to RESP; ack follows. Total latency RX_LAT+2 cycles.
  - Read of RXDATA with rx_avail=0: no rx_get, rx_unf set, rdata=0; go to RESP.
  - Reads of other registers go to RESP; rdata is the register value sampled at accept.
  - Unmapped address or addr[1:0]!=0: write ignored, read returns 0; go to RESP.
  - RESP asserts ack=1 for one cycle, then returns to IDLE.
- rdata holds its last value outside ack; consumers must qualify with ack.
- Sticky bit priority: a set event in the same cycle as a W1C of the same bit leaves the bit set.
- irq (registered) = (ie_rx & rx_avail) | (ie_tx & tx_empty) | (|{tx_ovf, rx_unf, fe_sticky}).
- A BAUD write takes effect on brd the cycle after accept, including mid-frame. Frame integrity across a baud change is software's responsibility.
- rst mid-transaction:
  - Abort to IDLE.
  - No ack is issued for the aborted request.
  - tx_wr and rx_get are deasserted the next cycle.

Test Plan:
1. Reset, then read BAUD and CTRL -> ack 1 cycle after accept; rdata=0x00000145 for BAUD and 0 for CTRL; brd=16'd325.
2. Write 0x5A to TXDATA with tx_full=0 -> tx_data=0x5A, tx_wr high exactly 1 cycle, ack coincident. Repeat with tx_full=1 -> no tx_wr; STATUS reads 0x12 (tx_full + tx_ovf). Write 0x10 to STATUS -> tx_ovf cleared.
3. rx_avail=1 and model returns rx_frame=10'b1_1010_0101_0 two cycles after rx_get -> one rx_get pulse; RXDATA=0x000000A5; ack at cycle RX_LAT+2.
4. Same read with rx_frame=10'b0_1010_0101_0 (bad stop bit) -> RXDATA=0x000001A5, fe_sticky=1, irq=1. Read with rx_avail=0 -> rdata=0, rx_unf=1, no rx_get.
5. Write CTRL=0x2 with tx_empty=1 -> irq rises 1 cycle later. Write BAUD=0x1234_0010 -> brd=16'h0010. Read of addr 0x14 -> ack with rdata=0.
6. Assert rst during RX_WAIT -> no ack, FSM returns to IDLE, outputs at reset values. A subsequent TXDATA write completes normally.
